tx_fifo_wr_ctrl: RTL and testbench
==================================

TX_FIFO_WR_CTRL -- requirements
Module: tx_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DAT_W, default 256, giving the data word width.
REQ-002 SHALL have parameter CNT_W, default 10, giving the word-count width.
REQ-003 SHALL have parameter MAX_WORDS, default 510, giving the largest legal transfer length (FIFO full threshold).
REQ-004 SHALL have port i_wr_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_wr_rstn, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port i_start, input, 1, a one-cycle request to begin a transfer.
REQ-007 SHALL have port i_num_words, input, CNT_W, the transfer length, sampled with i_start.
REQ-008 SHALL have port i_abort, input, 1, a synchronous cancel of the current transfer.
REQ-009 SHALL have port i_src_valid, input, 1, marking upstream (DDR3 read path) data as valid.
REQ-010 SHALL have port i_src_data, input, DAT_W, the upstream data word.
REQ-011 SHALL have port o_src_ready, output, 1, the upstream accept signal; a handshake occurs when i_src_valid and o_src_ready are both high.
REQ-012 SHALL have port o_wr_en, output, 1, the FIFO write request.
REQ-013 SHALL have port o_wr_data, output, DAT_W, the FIFO write data.
REQ-014 SHALL have port i_full, input, 1, the FIFO full flag (registered by the write-pointer stage; the FIFO ignores writes while it is high).
REQ-015 SHALL have port i_almost_full, input, 1, the FIFO almost-full flag, treated as a level.
REQ-016 SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port o_done, output, 1, a one-cycle pulse at transfer completion.
REQ-018 SHALL have port o_err, output, 1, a one-cycle pulse when a start request is rejected.
REQ-019 SHALL have port o_word_cnt, output, CNT_W, the number of words committed to the FIFO in the current transfer.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-021 In IDLE, i_start with 1 <= i_num_words <= MAX_WORDS SHALL latch the length, clear both counters and move to RUN next cycle.
REQ-022 In IDLE, i_start with i_num_words == 0 or > MAX_WORDS SHALL stay in IDLE and pulse o_err for one cycle on the next cycle.
REQ-023 i_start in any state other than IDLE SHALL be ignored, with no o_err.
REQ-024 o_src_ready SHALL equal: state==RUN, AND accepted count < length, AND ~i_almost_full, AND (~o_wr_en OR ~i_full).
REQ-025 On a handshake, i_src_data SHALL be registered to o_wr_data with o_wr_en high on the next cycle (latency 1), and the accepted count SHALL increment.
REQ-026 A write commits when o_wr_en && ~i_full; on commit, o_word_cnt SHALL increment by 1.
REQ-027 o_wr_en SHALL drop after a commit unless a new handshake occurred in the same cycle.
REQ-028 While o_wr_en && i_full, o_wr_data and o_wr_en SHALL hold unchanged; no word is lost or duplicated.
REQ-029 A commit and a new handshake in the same cycle SHALL load the new word back-to-back, sustaining 1 word/clock.
REQ-030 RUN SHALL move to DRAIN in the cycle the accepted count reaches the length.
REQ-031 DRAIN SHALL move to DONE once o_wr_en == 0 and o_word_cnt == length.
REQ-032 DONE SHALL pulse o_done for one cycle and return to IDLE; o_word_cnt SHALL hold its final value until the next accepted i_start.
REQ-033 i_abort in any state SHALL go to IDLE next cycle, drop o_wr_en (discarding any pending word) and hold o_word_cnt, with no o_done.
REQ-034 i_abort and i_start together in IDLE: i_abort SHALL win, with no transfer started and no o_err.
REQ-035 Counters SHALL never wrap; the length is at most MAX_WORDS < 2^CNT_W.
REQ-036 An i_src_valid drop mid-transfer SHALL only stall the block; there is no timeout.

Reset
REQ-037 While i_wr_rstn is low: state = IDLE; o_wr_en, o_src_ready, o_busy, o_done, o_err = 0; o_wr_data = 0; o_word_cnt = 0; internal counters and length = 0.
REQ-038 Reset assertion mid-transfer SHALL take effect immediately (asynchronously), with no FIFO write in the following cycles.
REQ-039 Release SHALL be synchronous to i_wr_clk, and the first i_start SHALL be honoured on the first active edge after release.

Verification
REQ-040 Streaming: i_start, i_num_words=4, i_src_valid always high, flags low -> 4 consecutive o_wr_en cycles with data D0..D3 in order; o_done 2 cycles after the last commit; o_word_cnt=4.
REQ-041 Full stall: i_full held high for 3 cycles while o_wr_en=1 -> o_wr_data stable, o_src_ready=0, no count increment; after release, exactly one commit of the held word.
REQ-042 Almost-full throttle: i_almost_full high -> o_src_ready=0 next evaluation; the pending word still commits if ~i_full.
REQ-043 Bad length: i_start with i_num_words=0, then 511 -> o_err pulses twice, o_busy stays 0.
REQ-044 Abort: i_abort after 2 of 8 words committed -> IDLE, o_wr_en=0, o_word_cnt=2, no o_done.
REQ-045 Reset: i_wr_rstn low for 1 cycle during RUN -> all outputs 0 immediately; a new 510-word transfer then completes with o_word_cnt=510.

Source files
------------

// File: rtl/tx_fifo_wr_ctrl.sv
// Write-side controller that moves a fixed-length burst from the DDR3 read path
// into the TX FIFO through a one-deep skid register, with abort and full back-pressure.
module tx_fifo_wr_ctrl #(
  parameter int DAT_W     = 256,
  parameter int CNT_W     = 10,
  parameter int MAX_WORDS = 510
) (
  input  logic             i_wr_clk,
  input  logic             i_wr_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_words,
  input  logic             i_abort,
  input  logic             i_src_valid,
  input  logic [DAT_W-1:0] i_src_data,
  output logic             o_src_ready,
  output logic             o_wr_en,
  output logic [DAT_W-1:0] o_wr_data,
  input  logic             i_full,
  input  logic             i_almost_full,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [DAT_W-1:0] data_p1;
  logic             vld_p1;
  logic             err_q;

  logic             len_ok;
  logic             start_ok;
  logic             start_bad;
  logic             hs;
  logic             commit;
  logic             acc_last;

  assign len_ok    = (i_num_words != '0) && (i_num_words <= MAX_LEN);
  assign start_ok  = (state_q == IDLE) && i_start && !i_abort && len_ok;
  assign start_bad = (state_q == IDLE) && i_start && !i_abort && !len_ok;

  // A held word blocks new input only while the FIFO is refusing it.
  assign o_src_ready = (state_q == RUN) && (acc_cnt_q < len_q) && !i_almost_full
                       && (!vld_p1 || !i_full);
  assign hs          = i_src_valid && o_src_ready;
  assign commit      = vld_p1 && !i_full;
  assign acc_last    = hs && ((acc_cnt_q + CNT_ONE) == len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (acc_last) state_d = DRAIN;
      DRAIN:   if (!vld_p1 && (word_cnt_q == len_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) state_d = IDLE;
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      len_q      <= '0;
      acc_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (start_ok) begin
      len_q      <= i_num_words;
      acc_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (!i_abort) begin
      if (hs)     acc_cnt_q  <= acc_cnt_q + CNT_ONE;
      if (commit) word_cnt_q <= word_cnt_q + CNT_ONE;
    end
  end

  // Stage p1: accepted word presented to the FIFO until it commits.
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (i_abort) begin
      vld_p1  <= 1'b0;
    end else if (hs) begin
      vld_p1  <= 1'b1;
      data_p1 <= i_src_data;
    end else if (commit) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= start_bad;
    end
  end

  assign o_wr_en    = vld_p1;
  assign o_wr_data  = data_p1;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_err      = err_q;
  assign o_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_tx_fifo_wr_ctrl.sv
// Scoreboard bench for tx_fifo_wr_ctrl: accepted words are queued and matched
// against FIFO commits; control outputs are checked against fixed expectations.
module tb_tx_fifo_wr_ctrl;
  localparam int DAT_W     = 256;
  localparam int CNT_W     = 10;
  localparam int MAX_WORDS = 510;

  logic             i_wr_clk = 1'b0;
  logic             i_wr_rstn;
  logic             i_start;
  logic [CNT_W-1:0] i_num_words;
  logic             i_abort;
  logic             i_src_valid;
  logic [DAT_W-1:0] i_src_data = '0;
  logic             o_src_ready;
  logic             o_wr_en;
  logic [DAT_W-1:0] o_wr_data;
  logic             i_full;
  logic             i_almost_full;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [CNT_W-1:0] o_word_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int commits = 0;
  logic hs_n = 1'b0;
  logic sb_flush = 1'b0;
  logic [DAT_W-1:0] sb_q[$];

  tx_fifo_wr_ctrl #(.DAT_W(DAT_W), .CNT_W(CNT_W), .MAX_WORDS(MAX_WORDS)) dut (
    .i_wr_clk(i_wr_clk), .i_wr_rstn(i_wr_rstn), .i_start(i_start),
    .i_num_words(i_num_words), .i_abort(i_abort), .i_src_valid(i_src_valid),
    .i_src_data(i_src_data), .o_src_ready(o_src_ready), .o_wr_en(o_wr_en),
    .o_wr_data(o_wr_data), .i_full(i_full), .i_almost_full(i_almost_full),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_word_cnt(o_word_cnt)
  );

  always #5 i_wr_clk = ~i_wr_clk;

  task automatic check(input string tag, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DAT_W-1:0] rnd_word();
    logic [DAT_W-1:0] w;
    for (int i = 0; i < DAT_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: commits pop the scoreboard, handshakes push the driven word.
  always @(negedge i_wr_clk) begin
    hs_n = 1'b0;
    if (sb_flush) begin
      sb_q.delete();
    end else if (i_wr_rstn) begin
      if (o_done) done_seen++;
      if (o_err) err_seen++;
      if (o_wr_en && !i_full) begin
        commits++;
        if (sb_q.size() == 0) check("sb_nonempty", DAT_W'(sb_q.size()), DAT_W'(1));
        else check("wr_data", o_wr_data, sb_q.pop_front());
      end
      if (i_src_valid && o_src_ready && !i_abort) begin
        sb_q.push_back(i_src_data);
        hs_n = 1'b1;
      end
    end
  end

  // Source: present a fresh word after every accepted one.
  always @(posedge i_wr_clk) begin
    #1;
    if (hs_n) i_src_data = rnd_word();
  end

  task automatic tick();
    @(posedge i_wr_clk);
    #1;
  endtask

  task automatic start_xfer(input int n);
    i_start = 1'b1;
    i_num_words = CNT_W'(n);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_wr_clk);
      if (o_done) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, DAT_W'(found), DAT_W'(1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, c0;
    logic [7:0] t_wr, t_done, t_busy;
    int t_cnt[8];

    i_wr_rstn = 1'b0; i_start = 1'b0; i_num_words = '0; i_abort = 1'b0;
    i_src_valid = 1'b0; i_full = 1'b0; i_almost_full = 1'b0;
    #2;
    check("rst_wr_en", DAT_W'(o_wr_en), '0);
    check("rst_ready", DAT_W'(o_src_ready), '0);
    check("rst_busy", DAT_W'(o_busy), '0);
    check("rst_done", DAT_W'(o_done), '0);
    check("rst_err", DAT_W'(o_err), '0);
    check("rst_cnt", DAT_W'(o_word_cnt), '0);
    check("rst_data", o_wr_data, '0);

    // Streaming 4 words; start is issued on the first edge after release.
    tick();
    i_wr_rstn = 1'b1;
    i_src_valid = 1'b1;
    d0 = done_seen;
    start_xfer(4);
    t_wr   = 8'b0001_1110;
    t_done = 8'b0100_0000;
    t_busy = 8'b0111_1111;
    t_cnt  = '{0, 0, 1, 2, 3, 4, 4, 4};
    for (int k = 0; k < 8; k++) begin
      @(negedge i_wr_clk);
      check($sformatf("stream_wr_en_c%0d", k + 1), DAT_W'(o_wr_en), DAT_W'(t_wr[k]));
      check($sformatf("stream_done_c%0d", k + 1), DAT_W'(o_done), DAT_W'(t_done[k]));
      check($sformatf("stream_busy_c%0d", k + 1), DAT_W'(o_busy), DAT_W'(t_busy[k]));
      check($sformatf("stream_cnt_c%0d", k + 1), DAT_W'(o_word_cnt), DAT_W'(t_cnt[k]));
      tick();
    end
    check("stream_done_pulses", DAT_W'(done_seen - d0), DAT_W'(1));
    check("stream_sb_empty", DAT_W'(sb_q.size()), '0);

    // Full stall for 3 cycles with a word pending.
    start_xfer(6);
    tick();
    i_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      check("stall_ready", DAT_W'(o_src_ready), '0);
      check("stall_wr_en", DAT_W'(o_wr_en), DAT_W'(1));
      check("stall_data", o_wr_data, sb_q[0]);
      check("stall_cnt", DAT_W'(o_word_cnt), '0);
    end
    tick();
    i_full = 1'b0;
    wait_done("stall_done", 50);
    check("stall_final_cnt", DAT_W'(o_word_cnt), DAT_W'(6));
    check("stall_sb_empty", DAT_W'(sb_q.size()), '0);

    // Almost-full throttle; a start while busy must be ignored.
    start_xfer(4);
    tick();
    i_almost_full = 1'b1;
    i_start = 1'b1;
    i_num_words = '0;
    #1;
    check("af_ready", DAT_W'(o_src_ready), '0);
    check("af_wr_en", DAT_W'(o_wr_en), DAT_W'(1));
    tick();
    i_start = 1'b0;
    #1;
    check("af_committed", DAT_W'(o_word_cnt), DAT_W'(1));
    check("af_wr_en_drop", DAT_W'(o_wr_en), '0);
    check("af_busy_start_no_err", DAT_W'(o_err), '0);
    tick();
    i_almost_full = 1'b0;
    wait_done("af_done", 50);
    check("af_final_cnt", DAT_W'(o_word_cnt), DAT_W'(4));
    check("af_sb_empty", DAT_W'(sb_q.size()), '0);

    // Illegal lengths, then abort beating start in IDLE.
    i_src_valid = 1'b0;
    e0 = err_seen;
    start_xfer(0);
    #1;
    check("bad0_err", DAT_W'(o_err), DAT_W'(1));
    check("bad0_busy", DAT_W'(o_busy), '0);
    tick();
    #1;
    check("bad0_err_one_cycle", DAT_W'(o_err), '0);
    start_xfer(MAX_WORDS + 1);
    #1;
    check("bad511_err", DAT_W'(o_err), DAT_W'(1));
    check("bad511_busy", DAT_W'(o_busy), '0);
    tick();
    check("bad_err_pulses", DAT_W'(err_seen - e0), DAT_W'(2));
    i_abort = 1'b1;
    start_xfer(4);
    i_abort = 1'b0;
    #1;
    check("abort_start_busy", DAT_W'(o_busy), '0);
    check("abort_start_err", DAT_W'(o_err), '0);

    // Abort after 2 of 8 words committed, third word held by full.
    i_src_valid = 1'b1;
    d0 = done_seen;
    start_xfer(8);
    tick(); tick(); tick();
    i_full = 1'b1;
    i_abort = 1'b1;
    #1;
    check("abort_pre_cnt", DAT_W'(o_word_cnt), DAT_W'(2));
    tick();
    i_abort = 1'b0;
    i_full = 1'b0;
    i_src_valid = 1'b0;
    sb_flush = 1'b1;
    #1;
    check("abort_busy", DAT_W'(o_busy), '0);
    check("abort_wr_en", DAT_W'(o_wr_en), '0);
    check("abort_cnt", DAT_W'(o_word_cnt), DAT_W'(2));
    tick(); tick(); tick();
    sb_flush = 1'b0;
    check("abort_cnt_hold", DAT_W'(o_word_cnt), DAT_W'(2));
    check("abort_no_done", DAT_W'(done_seen - d0), '0);

    // Asynchronous reset mid-transfer, then a full-length transfer.
    i_src_valid = 1'b1;
    start_xfer(10);
    tick(); tick();
    #1;
    i_wr_rstn = 1'b0;
    sb_flush = 1'b1;
    #1;
    check("arst_wr_en", DAT_W'(o_wr_en), '0);
    check("arst_ready", DAT_W'(o_src_ready), '0);
    check("arst_busy", DAT_W'(o_busy), '0);
    check("arst_done", DAT_W'(o_done), '0);
    check("arst_err", DAT_W'(o_err), '0);
    check("arst_cnt", DAT_W'(o_word_cnt), '0);
    check("arst_data", o_wr_data, '0);
    tick();
    check("arst_no_write", DAT_W'(o_wr_en), '0);
    i_wr_rstn = 1'b1;
    tick();
    sb_flush = 1'b0;
    c0 = commits;
    start_xfer(MAX_WORDS);
    wait_done("max_done", 700);
    check("max_final_cnt", DAT_W'(o_word_cnt), DAT_W'(MAX_WORDS));
    check("max_commits", DAT_W'(commits - c0), DAT_W'(MAX_WORDS));
    check("max_sb_empty", DAT_W'(sb_q.size()), '0);
    i_src_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
